// File: rtl/unidade_controle_siga.sv
// Control FSM for "siga a musica": plays rounds 0..R, then checks the player's repetition.
// Optional macro TIMEOUT_EN: a player timeout in ESPERA counts as a wrong note.
module unidade_controle_siga #(
  parameter int ERRO      = 3,
  parameter int MAX_ERROS = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iniciar,
  input  logic            nota_feita,
  input  logic            nota_correta,
  input  logic            enderecoIgualRodada,
  input  logic            fim_musica,
  input  logic            fimTF,
  input  logic            fimTempo,
  output logic            zeraC,
  output logic            contaC,
  output logic            zeraCR,
  output logic            contaCR,
  output logic            zeraTF,
  output logic            contaTF,
  output logic            zeraTempo,
  output logic            contaTempo,
  output logic            zeraR,
  output logic            registraR,
  output logic            leds_mem,
  output logic            ativa_leds,
  output logic            toca,
  output logic [ERRO-1:0] erros,
  output logic            acertou,
  output logic            errou,
  output logic            pronto,
  output logic [3:0]      db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    MOSTRA      = 4'd2,
    PROX_MOSTRA = 4'd3,
    INICIA_JOG  = 4'd4,
    ESPERA      = 4'd5,
    REGISTRA    = 4'd6,
    COMPARA     = 4'd7,
    ACERTO_FB   = 4'd8,
    PROX_END    = 4'd9,
    PROX_ROD    = 4'd10,
    ERRO_FB     = 4'd11,
    FIM_ACERTO  = 4'd12,
    FIM_ERRO    = 4'd13
  } estado_t;

  localparam logic [ERRO-1:0] ERROS_SAT = '1;
  localparam logic [ERRO-1:0] ERROS_MAX = ERRO'(MAX_ERROS);

  estado_t         estado_q;
  logic [ERRO-1:0] erros_q;
  logic [ERRO-1:0] erros_inc;
  logic            nota_q;
  logic            nota_borda;
  logic            timeout;
  logic            limite_erros;

  assign nota_borda   = nota_feita & ~nota_q;
  assign erros_inc    = (erros_q == ERROS_SAT) ? erros_q : erros_q + 1'b1;
  assign limite_erros = (erros_q >= ERROS_MAX);

`ifdef TIMEOUT_EN
  assign timeout = fimTempo;
`else
  logic unused_fimtempo;
  assign unused_fimtempo = fimTempo;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIAL;
      erros_q  <= '0;
      nota_q   <= 1'b0;
    end else begin
      nota_q <= nota_feita;
      case (estado_q)
        INICIAL:     if (iniciar) estado_q <= PREPARA;
        PREPARA: begin
          erros_q  <= '0;
          estado_q <= MOSTRA;
        end
        MOSTRA:      if (fimTF) estado_q <= PROX_MOSTRA;
        PROX_MOSTRA: estado_q <= enderecoIgualRodada ? INICIA_JOG : MOSTRA;
        INICIA_JOG:  estado_q <= ESPERA;
        // a fresh key edge wins over a timeout in the same cycle
        ESPERA: begin
          if (nota_borda) begin
            estado_q <= REGISTRA;
          end else if (timeout) begin
            estado_q <= ERRO_FB;
            erros_q  <= erros_inc;
          end
        end
        REGISTRA:    estado_q <= COMPARA;
        COMPARA: begin
          if (nota_correta) begin
            estado_q <= ACERTO_FB;
          end else begin
            estado_q <= ERRO_FB;
            erros_q  <= erros_inc;
          end
        end
        ACERTO_FB:   if (fimTF) estado_q <= PROX_END;
        PROX_END: begin
          if (fim_musica && enderecoIgualRodada) estado_q <= FIM_ACERTO;
          else if (enderecoIgualRodada)          estado_q <= PROX_ROD;
          else                                   estado_q <= ESPERA;
        end
        PROX_ROD:    estado_q <= MOSTRA;
        ERRO_FB:     if (fimTF) estado_q <= limite_erros ? FIM_ERRO : MOSTRA;
        FIM_ACERTO,
        FIM_ERRO:    if (iniciar) estado_q <= PREPARA;
        default:     estado_q <= INICIAL;
      endcase
    end
  end

  always_comb begin
    zeraC      = 1'b0;
    contaC     = 1'b0;
    zeraCR     = 1'b0;
    contaCR    = 1'b0;
    zeraTF     = 1'b0;
    contaTF    = 1'b0;
    zeraTempo  = 1'b0;
    contaTempo = 1'b0;
    zeraR      = 1'b0;
    registraR  = 1'b0;
    leds_mem   = 1'b0;
    ativa_leds = 1'b0;
    toca       = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    pronto     = 1'b0;
    case (estado_q)
      PREPARA: begin
        zeraC     = 1'b1;
        zeraCR    = 1'b1;
        zeraR     = 1'b1;
        zeraTF    = 1'b1;
        zeraTempo = 1'b1;
      end
      MOSTRA: begin
        leds_mem   = 1'b1;
        ativa_leds = 1'b1;
        toca       = 1'b1;
        contaTF    = 1'b1;
      end
      PROX_MOSTRA: begin
        zeraTF = 1'b1;
        contaC = ~enderecoIgualRodada;
      end
      INICIA_JOG: begin
        zeraC     = 1'b1;
        zeraR     = 1'b1;
        zeraTempo = 1'b1;
      end
`ifdef TIMEOUT_EN
      ESPERA:    contaTempo = 1'b1;
`endif
      REGISTRA: begin
        registraR = 1'b1;
        zeraTempo = 1'b1;
      end
      ACERTO_FB: begin
        ativa_leds = 1'b1;
        toca       = 1'b1;
        contaTF    = 1'b1;
      end
      PROX_END: begin
        zeraTF = 1'b1;
        contaC = ~enderecoIgualRodada;
      end
      PROX_ROD: begin
        contaCR = 1'b1;
        zeraC   = 1'b1;
        zeraR   = 1'b1;
      end
      ERRO_FB: begin
        contaTF = 1'b1;
        zeraC   = fimTF & ~limite_erros;
      end
      FIM_ACERTO: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      FIM_ERRO: begin
        errou  = 1'b1;
        pronto = 1'b1;
      end
      default: ;
    endcase
  end

  assign erros     = erros_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_siga.sv
// Directed bench: driver pushes expected state/erros per transition; monitor pops on each state change.
module tb_unidade_controle_siga;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0, nota_feita = 1'b0, nota_correta = 1'b0;
  logic enderecoIgualRodada = 1'b0, fim_musica = 1'b0, fimTF = 1'b0, fimTempo = 1'b0;
  logic zeraC, contaC, zeraCR, contaCR, zeraTF, contaTF, zeraTempo, contaTempo;
  logic zeraR, registraR, leds_mem, ativa_leds, toca, acertou, errou, pronto;
  logic [2:0] erros;
  logic [3:0] db_estado;

  unidade_controle_siga #(.ERRO(3), .MAX_ERROS(3)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .nota_feita(nota_feita),
    .nota_correta(nota_correta), .enderecoIgualRodada(enderecoIgualRodada),
    .fim_musica(fim_musica), .fimTF(fimTF), .fimTempo(fimTempo),
    .zeraC(zeraC), .contaC(contaC), .zeraCR(zeraCR), .contaCR(contaCR),
    .zeraTF(zeraTF), .contaTF(contaTF), .zeraTempo(zeraTempo), .contaTempo(contaTempo),
    .zeraR(zeraR), .registraR(registraR), .leds_mem(leds_mem), .ativa_leds(ativa_leds),
    .toca(toca), .erros(erros), .acertou(acertou), .errou(errou), .pronto(pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] s;
    logic [2:0] e;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         npress = 0;
  int         nreg = 0;
  logic [3:0] cur = 4'd0;
  logic [2:0] e_err = 3'd0;
  logic [3:0] prev = 4'd0;
  logic [15:0] ctrl;

  assign ctrl = {zeraC, contaC, zeraCR, contaCR, zeraTF, contaTF, zeraTempo, contaTempo,
                 zeraR, registraR, leds_mem, ativa_leds, toca, acertou, errou, pronto};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: every state change must match the next queued expectation
  always @(negedge clock) begin
    if (registraR === 1'b1) nreg++;
    if (db_estado !== prev) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transition: got %0d from %0d, nothing expected", db_estado, prev);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("state", db_estado, x.s);
        chk("erros", erros, x.e);
        chk("flags", {acertou, errou, pronto, registraR, leds_mem},
            {x.s == 4'd12, x.s == 4'd13, x.s >= 4'd12, x.s == 4'd6, x.s == 4'd2});
      end
    end
    prev = db_estado;
  end

  task automatic go(input logic [3:0] s);
    if (s != cur) q.push_back({s, e_err});
    cur = s;
    @(negedge clock);
  endtask

  task automatic show_round(input int r);
    for (int a = 0; a <= r; a++) begin
      fimTF = 1'b0;
      go(4'd2);
      fimTF = 1'b1;
      go(4'd3);
      fimTF = 1'b0;
      enderecoIgualRodada = (a == r);
      go((a == r) ? 4'd4 : 4'd2);
      enderecoIgualRodada = 1'b0;
    end
    go(4'd5);
  endtask

  task automatic press(input logic ok, input logic hold);
    nota_feita = 1'b0;
    go(4'd5);
    nota_feita = 1'b1;
    npress++;
    go(4'd6);
    go(4'd7);
    nota_correta = ok;
    if (ok) begin
      go(4'd8);
      nota_correta = 1'b0;
      go(4'd8);
      fimTF = 1'b1;
      go(4'd9);
      fimTF = 1'b0;
      if (!hold) nota_feita = 1'b0;
    end else begin
      e_err = (e_err == 3'd7) ? 3'd7 : e_err + 3'd1;
      go(4'd11);
      nota_correta = 1'b0;
      nota_feita = 1'b0;
      fimTF = 1'b1;
      go((e_err >= 3'd3) ? 4'd13 : 4'd2);
      fimTF = 1'b0;
    end
  endtask

  task automatic prox_end(input logic eir, input logic fim);
    enderecoIgualRodada = eir;
    fim_musica = fim;
    go((fim && eir) ? 4'd12 : (eir ? 4'd10 : 4'd5));
    enderecoIgualRodada = 1'b0;
    fim_musica = 1'b0;
    if (eir && !fim) go(4'd2);
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    go(4'd1);
    iniciar = 1'b0;
    e_err = 3'd0;
    go(4'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_state", db_estado, 0);
    chk("rst_erros", erros, 0);
    chk("rst_ctrl", ctrl, 0);
    reset = 1'b0;
    go(4'd0);

    // full 3-note song, all correct; one key held into ESPERA, iniciar ignored mid-game
    start_game();
    for (int r = 0; r <= 2; r++) begin
      show_round(r);
      for (int a = 0; a <= r; a++) begin
        if (r == 2 && a == 1) begin
          iniciar = 1'b1;
          go(4'd5);
          iniciar = 1'b0;
        end
        press(1'b1, (r == 1 && a == 0));
        prox_end(a == r, r == 2);
        if (r == 1 && a == 0) go(4'd5);
      end
    end
    go(4'd12);

    // lose game: wrong notes replay the round until three errors
    start_game();
    show_round(0);
    press(1'b1, 1'b0);
    prox_end(1'b1, 1'b0);
    show_round(1);
    press(1'b1, 1'b0);
    prox_end(1'b0, 1'b0);
    press(1'b0, 1'b0);
    show_round(1);
    press(1'b0, 1'b0);
    show_round(1);
    press(1'b1, 1'b0);
    prox_end(1'b0, 1'b0);
    press(1'b0, 1'b0);
    go(4'd13);
    iniciar = 1'b1;
    go(4'd1);
    iniciar = 1'b0;
    e_err = 3'd0;
    go(4'd2);

    // timeout behaviour, then key edge beating a simultaneous timeout
    show_round(0);
    fimTempo = 1'b1;
`ifdef TIMEOUT_EN
    chk("contaTempo_on", contaTempo, 1);
    e_err = e_err + 3'd1;
    go(4'd11);
    fimTempo = 1'b0;
    fimTF = 1'b1;
    go(4'd2);
    fimTF = 1'b0;
    show_round(0);
`else
    for (int i = 0; i < 4; i++) go(4'd5);
    chk("contaTempo_tied", contaTempo, 0);
    fimTempo = 1'b0;
`endif
    nota_feita = 1'b0;
    go(4'd5);
    nota_feita = 1'b1;
    fimTempo = 1'b1;
    npress++;
    go(4'd6);
    fimTempo = 1'b0;
    go(4'd7);
    nota_correta = 1'b0;
    e_err = e_err + 3'd1;
    go(4'd11);
    nota_feita = 1'b0;
    fimTF = 1'b1;
    go(4'd2);
    fimTF = 1'b0;
    go(4'd2);

    // asynchronous reset in MOSTRA with erros nonzero
    @(posedge clock);
    #3;
    q.push_back({4'd0, 3'd0});
    reset = 1'b1;
    #1;
    chk("rst_async_state", db_estado, 0);
    chk("rst_async_erros", erros, 0);
    chk("rst_async_ctrl", ctrl, 0);
    @(negedge clock);
    #1 reset = 1'b0;
    cur = 4'd0;
    e_err = 3'd0;
    @(negedge clock);
    go(4'd0);
    go(4'd0);

    chk("registraR_pulses", nreg, npress);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
